vga_fetch_arbiter: RTL
======================

// Module: vga_fetch_arbiter
// PURPOSE
//  Shares one single-port frame-buffer memory between two users: display fetch (fills the pixel FIFO that the
//  VGA timing block drains) and a drawing-engine writer. Burst-fetches pixels in raster order ahead of the scan.
//  Raises done once the FIFO is primed, so the VGA timing block starts counting. Flags FIFO underrun.
// PARAMETERS
//  DATA_W      8        pixel / memory data width
//  ADDR_W      19       frame-buffer address width (640*480 = 307200 < 2^19)
//  H_ACT       640      active pixels per line
//  V_ACT       480      active lines per frame
//  FIFO_DEPTH  16       pixel FIFO depth; fifo_level is $clog2(FIFO_DEPTH)+1 bits wide
//  BURST       8        reads per display burst
//  LOW_WM      4        fifo_level below this makes the fetch urgent
// PORTS
//  clk          in   1       single clock
//  rst          in   1       asynchronous, active-low reset (asserted at 0)
//  frame_start  in   1       1-cycle pulse at vsync start; restarts fetch at address 0
//  fifo_level   in   LW      current pixel-FIFO occupancy
//  fifo_rd      in   1       FIFO pop by display this cycle
//  fifo_wr      out  1       push fetched pixel into FIFO
//  fifo_wdata   out  DATA_W  pixel pushed
//  wr_req       in   1       writer request; held with wr_addr/wr_data until wr_gnt
//  wr_addr      in   ADDR_W  writer address
//  wr_data      in   DATA_W  writer data
//  wr_gnt       out  1       1-cycle pulse: write accepted by memory
//  mem_req      out  1       memory request; held with addr/we/wdata until mem_ack
//  mem_we       out  1       1 = write, 0 = read
//  mem_addr     out  ADDR_W  memory address
//  mem_wdata    out  DATA_W  memory write data
//  mem_ack      in   1       1-cycle completion; mem_rdata valid in the same cycle
//  mem_rdata    in   DATA_W  read data
//  done         out  1       sticky: FIFO primed; drives the VGA timing block's done input
//  underrun     out  1       sticky: fifo_rd seen while fifo_level==0 and done==1
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, fetch address 0, restart flag clear. A mem_ack arriving after reset is ignored.
//  One memory transaction outstanding at a time. mem_req never drops before mem_ack.
//  Priority, evaluated in IDLE only:
//   (1) urgent fetch: fifo_level < LOW_WM
//   (2) write: wr_req
//   (3) opportunistic fetch: fifo_level <= FIFO_DEPTH-BURST
//   Urgent fetch and write requests on the same cycle: fetch wins. No fetch starts while fifo_wr is pending.
//  States:
//   IDLE: pick per the priority above; mem_req=0.
//   FETCH: issue BURST sequential reads. On each mem_ack: the next cycle, fifo_wr=1 and fifo_wdata=registered
//     mem_rdata (latency 1); the address increments. After the BURST-th ack, go to IDLE. wr_req never
//     preempts a burst.
//   WRITE: mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data. On mem_ack, wr_gnt=1 in the same cycle, then IDLE.
//  Address: wraps from H_ACT*V_ACT-1 to 0.
//  frame_start: sets a restart flag. The address goes to 0 at the next burst start, never mid-burst; the flag
//   then clears. frame_start in the same cycle as a burst start: that burst begins at 0.
//  done: 0 -> 1 on the first cycle with fifo_level >= FIFO_DEPTH-BURST; stays 1 until reset.
//  underrun: set per the port description, and never cleared except by reset; fetch continues regardless.
//  Reset mid-burst: the burst is abandoned; no fifo_wr is issued for the in-flight read.
// STRUCTURE
//  vga_pkg: H_ACT, V_ACT, FRAME_PIXELS = H_ACT*V_ACT, and the arb_state_t enum {IDLE, FETCH, WRITE}.
//  Sub-module vga_fetch_addr_gen: linear address counter with increment, wrap at FRAME_PIXELS-1, and
//   restart-at-burst-boundary logic. The arbiter FSM, burst counter and flags stay in this module.
// TESTING
//  1. Reset, fifo_level=0, memory acks every cycle -> 8 reads at addr 0..7, fifo_wr lags each ack by 1;
//     done=1 once fifo_level>=8.
//  2. fifo_level=10, wr_req with wr_addr=0x100, wr_data=0xAB -> mem_we=1 at 0x100 with data 0xAB;
//     wr_gnt pulses on the ack cycle.
//  3. fifo_level=3 and wr_req on the same cycle -> fetch burst first; wr_gnt only after the 8th read ack.
//  4. Fetch address at 307196, burst of 8 -> addresses 307196..307199 then 0..3.
//  5. frame_start mid-burst at address 1000 -> burst completes to 1007; the next burst starts at 0.
//  6. done=1, fifo_level=0, fifo_rd=1 -> underrun=1 and stays 1; then rst=0 mid-burst -> all outputs 0
//     immediately; a late mem_ack gives no fifo_wr.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA frame-buffer fetch path.
package vga_pkg;

  localparam int unsigned H_ACT        = 640;
  localparam int unsigned V_ACT        = 480;
  localparam int unsigned FRAME_PIXELS = H_ACT * V_ACT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/vga_fetch_addr_gen.sv
// Raster-order fetch address counter; a frame restart is deferred to the next burst boundary.
module vga_fetch_addr_gen
  import vga_pkg::*;
#(
  parameter int unsigned ADDR_W    = 19,
  parameter int unsigned FRAME_LEN = FRAME_PIXELS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              inc,
  input  logic              frame_start,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FRAME_LEN - 1);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              restart_q, restart_d;

  always_comb begin
    addr_d    = addr_q;
    restart_d = restart_q;
    if (start) begin
      // A frame_start coinciding with the burst start still takes effect for this burst.
      restart_d = 1'b0;
      if (restart_q || frame_start) begin
        addr_d = '0;
      end
    end else begin
      if (frame_start) begin
        restart_d = 1'b1;
      end
      if (inc) begin
        addr_d = (addr_q == LastAddr) ? '0 : addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      restart_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      restart_q <= restart_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/vga_fetch_arbiter.sv
// Arbitrates one single-port frame buffer between display burst fetch and the drawing writer.
module vga_fetch_arbiter
  import vga_pkg::arb_state_t, vga_pkg::IDLE, vga_pkg::FETCH, vga_pkg::WRITE;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned H_ACT      = 640,
  parameter int unsigned V_ACT      = 480,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned BURST      = 8,
  parameter int unsigned LOW_WM     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_start,
  input  logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  input  logic                         fifo_rd,
  output logic                         fifo_wr,
  output logic [DATA_W-1:0]            fifo_wdata,
  input  logic                         wr_req,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  output logic                         wr_gnt,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic                         mem_ack,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic                         done,
  output logic                         underrun
);

  localparam int unsigned     LW       = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned     BW       = $clog2(BURST + 1);
  localparam logic [LW-1:0]   LowWm    = LW'(LOW_WM);
  localparam logic [LW-1:0]   OppLevel = LW'(FIFO_DEPTH - BURST);
  localparam logic [BW-1:0]   LastBeat = BW'(BURST - 1);

  arb_state_t        state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic              fifo_wr_q;
  logic [DATA_W-1:0] fifo_wdata_q;
  logic              done_q, underrun_q;
  logic              burst_start, read_ack, fetch_ok;
  logic [ADDR_W-1:0] fetch_addr;

  assign read_ack = (state_q == FETCH) && mem_ack;
  // Holding off a new burst while the last pixel is still being pushed lets a waiting writer in.
  assign fetch_ok = !fifo_wr_q;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    burst_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fetch_ok && (fifo_level < LowWm)) begin
          burst_start = 1'b1;
        end else if (wr_req) begin
          state_d = WRITE;
        end else if (fetch_ok && (fifo_level <= OppLevel)) begin
          burst_start = 1'b1;
        end
        if (burst_start) begin
          state_d = FETCH;
          beat_d  = '0;
        end
      end
      FETCH: begin
        if (mem_ack) begin
          if (beat_q == LastBeat) begin
            state_d = IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      WRITE: begin
        if (mem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      fifo_wr_q    <= 1'b0;
      fifo_wdata_q <= '0;
      done_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      fifo_wr_q <= read_ack;
      if (read_ack) begin
        fifo_wdata_q <= mem_rdata;
      end
      if (fifo_level >= OppLevel) begin
        done_q <= 1'b1;
      end
      if (fifo_rd && (fifo_level == '0) && done_q) begin
        underrun_q <= 1'b1;
      end
    end
  end

  vga_fetch_addr_gen #(
    .ADDR_W    (ADDR_W),
    .FRAME_LEN (H_ACT * V_ACT)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .start       (burst_start),
    .inc         (read_ack),
    .frame_start (frame_start),
    .addr        (fetch_addr)
  );

  assign fifo_wr    = fifo_wr_q;
  assign fifo_wdata = fifo_wdata_q;
  assign mem_req    = (state_q != IDLE);
  assign mem_we     = (state_q == WRITE);
  assign mem_addr   = (state_q == WRITE) ? wr_addr :
                      (state_q == FETCH) ? fetch_addr : '0;
  assign mem_wdata  = (state_q == WRITE) ? wr_data : '0;
  assign wr_gnt     = (state_q == WRITE) && mem_ack;
  assign done       = done_q;
  assign underrun   = underrun_q;

endmodule
